// File: rtl/wisc_rf_pkg.sv
// Shared types and helpers for the WISC parametrised register file.
// Holds the dump FSM encoding, default sizes and port slice math.
package wisc_rf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } dump_state_t;

  localparam int RF_DATA_W   = 16;
  localparam int RF_NUM_REGS = 16;

  // LSB of port `port` inside a packed bus of `w`-bit fields
  function automatic int unsigned slice_lsb(
    input int unsigned port,
    input int unsigned w
  );
    return port * w;
  endfunction

endpackage

// File: rtl/reg_dump_seq.sv
// Dump sequencer: walks every register index once per request
// and presents it on a valid/ready stream, then pulses done.
module reg_dump_seq
  import wisc_rf_pkg::*;
#(
  parameter  int NUM_REGS = RF_NUM_REGS,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dump_req,
  input  logic          dump_ready,
  output logic          dump_valid,
  output logic [AW-1:0] dump_addr,
  output logic          dump_busy,
  output logic          dump_done
);

  localparam logic [AW-1:0] LAST = AW'(NUM_REGS - 1);

  dump_state_t   state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dump_valid = 1'b0;
    dump_busy  = 1'b0;
    dump_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dump_req) begin
          state_d = STREAM;
          idx_d   = '0;
        end
      end
      STREAM: begin
        dump_valid = 1'b1;
        dump_busy  = 1'b1;
        if (dump_ready) begin
          // the index parks at 0 rather than wrapping past the last beat
          if (idx_q == LAST) begin
            state_d = DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
      DONE: begin
        dump_done = 1'b1;
        dump_busy = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dump_addr = idx_q;

endmodule

// File: rtl/param_reg_file.sv
// Parametrised WISC register file with write bypass, optional
// hardwired R0 and a handshaked dump port for state inspection.
module param_reg_file
  import wisc_rf_pkg::*;
#(
  parameter  int DATA_W   = RF_DATA_W,
  parameter  int NUM_REGS = RF_NUM_REGS,
  parameter  int NUM_RD   = 2,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     dump_req,
  input  logic                     dump_ready,
  output logic                     dump_valid,
  output logic [AW-1:0]            dump_addr,
  output logic [DATA_W-1:0]        dump_data,
  output logic                     dump_busy,
  output logic                     dump_done
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              wr_ok;

  assign wr_ok = wr_en && !(ZERO_REG != 0 && wr_addr == '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_ok) regs_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // one read path shared by every read port and the dump stream
  function automatic logic [DATA_W-1:0] read_reg(
    input logic [AW-1:0] a
  );
    if (ZERO_REG != 0 && a == '0) return '0;
    if (BYPASS != 0 && wr_ok && wr_addr == a) return wr_data;
    return regs_q[a];
  endfunction

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      rd_data[slice_lsb(i, DATA_W) +: DATA_W] =
        read_reg(rd_addr[slice_lsb(i, AW) +: AW]);
    end
  end

  reg_dump_seq #(
    .NUM_REGS(NUM_REGS)
  ) u_seq (
    .clk       (clk),
    .rst       (rst),
    .dump_req  (dump_req),
    .dump_ready(dump_ready),
    .dump_valid(dump_valid),
    .dump_addr (dump_addr),
    .dump_busy (dump_busy),
    .dump_done (dump_done)
  );

  assign dump_data = read_reg(dump_addr);

endmodule
